// File: rtl/jk_reg_ctrl.sv
// jk_reg_ctrl: command sequencer driving a WIDTH-bit bank of JK flip-flops.
// The cells have no reset pin; reset is applied as J=0/K=1 through the JK inputs.
module jk_reg_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [3:0]       cmd_len,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_CLEAR  = 3'd2,
    OP_SET    = 3'd3,
    OP_TOGGLE = 3'd4,
    OP_COUNT  = 3'd5,
    OP_SHIFT  = 3'd6,
    OP_RSVD   = 3'd7
  } op_t;

  state_t           state, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       cnt, cnt_d;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] cnt_tgl;
  logic [WIDTH-1:0] shift_nxt;

  assign busy = (state != IDLE);

  // Next-state, command latch and handshake outputs
  always_comb begin
    state_d   = state;
    op_d      = op_q;
    data_d    = data_q;
    cnt_d     = cnt;
    cmd_ready = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = op_t'(cmd_op);
          data_d  = cmd_data;
          cnt_d   = (cmd_op == OP_COUNT || cmd_op == OP_SHIFT) ? cmd_len : '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) state_d = DONE;
        else           cnt_d   = cnt - 4'd1;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_HOLD;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      op_q   <= op_d;
      data_q <= data_d;
      cnt    <= cnt_d;
    end
  end

  // Ripple-carry toggle enables for the counter: bit i toggles when all lower bits are 1
  always_comb begin
    cnt_tgl    = '1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      cnt_tgl[i] = cnt_tgl[i-1] & q[i-1];
    end
  end

  assign shift_nxt = {q[WIDTH-2:0], data_q[0]};

  // J/K drive per cell; reset overrides any operation in progress
  always_comb begin
    j = '0;
    k = '0;
    if (!rst_n) begin
      k = '1;
    end else if (state == EXEC) begin
      case (op_q)
        OP_LOAD:   begin j = data_q;    k = ~data_q;    end
        OP_CLEAR:  begin               k = '1;          end
        OP_SET:    begin j = '1;                        end
        OP_TOGGLE: begin j = data_q;    k = data_q;     end
        OP_COUNT:  begin j = cnt_tgl;   k = cnt_tgl;    end
        OP_SHIFT:  begin j = shift_nxt; k = ~shift_nxt; end
        default:   begin j = '0;        k = '0;         end
      endcase
    end
  end

  // JK storage cells: hold / reset / set / toggle
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    always_ff @(posedge clk) begin
      case ({j[g], k[g]})
        2'b01:   q[g] <= 1'b0;
        2'b10:   q[g] <= 1'b1;
        2'b11:   q[g] <= ~q[g];
        default: q[g] <= q[g];
      endcase
    end
  end

endmodule

// File: tb/tb_jk_reg_ctrl.sv
// Directed testbench for jk_reg_ctrl (WIDTH=4) with a queue of expected q values.
module tb_jk_reg_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_len;
  logic [3:0] q;
  logic       busy;
  logic       done;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [3:0]  model_q;
  logic [3:0]  exp_q[$];

  jk_reg_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .q         (q),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] model_step(input logic [2:0] op, input logic [3:0] d,
                                            input logic [3:0] cur);
    case (op)
      3'd1:    return d;
      3'd2:    return 4'b0000;
      3'd3:    return 4'b1111;
      3'd4:    return cur ^ d;
      3'd5:    return cur + 4'd1;
      3'd6:    return {cur[2:0], d[0]};
      default: return cur;
    endcase
  endfunction

  // Issue one command, score every q update, then the done and ready-return cycles.
  // With noise set, a different command is presented throughout EXEC and must be ignored.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [3:0] d,
                        input logic [3:0] len, input bit noise);
    int unsigned steps;
    int unsigned n;
    logic [3:0]  m;
    logic [3:0]  e;
    steps = (op == 3'd5 || op == 3'd6) ? int'(len) + 1 : 1;
    m = model_q;
    for (int unsigned s = 0; s < steps; s++) begin
      m = model_step(op, d, m);
      exp_q.push_back(m);
    end
    @(negedge clk);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_before"}, {3'b0, cmd_ready}, 4'b0001);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_len   = len;
    @(posedge clk); #1;
    if (noise) begin
      cmd_op   = 3'd3;
      cmd_data = 4'b1001;
      cmd_len  = 4'd7;
    end else begin
      cmd_valid = 1'b0;
      cmd_data  = 4'($urandom);
    end
    check({tag, "_busy"}, {3'b0, busy}, 4'b0001);
    check({tag, "_ready_low"}, {3'b0, cmd_ready}, 4'b0000);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check({tag, "_q"}, q, e);
      if (exp_q.size() > 0) check({tag, "_done_early"}, {3'b0, done}, 4'b0000);
    end
    cmd_valid = 1'b0;
    check({tag, "_done"}, {3'b0, done}, 4'b0001);
    check({tag, "_ready_in_done"}, {3'b0, cmd_ready}, 4'b0000);
    @(posedge clk); #1;
    check({tag, "_done_clear"}, {3'b0, done}, 4'b0000);
    check({tag, "_ready_back"}, {3'b0, cmd_ready}, 4'b0001);
    check({tag, "_busy_clear"}, {3'b0, busy}, 4'b0000);
    check({tag, "_q_after"}, q, m);
    model_q = m;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 4'd0;
    cmd_len   = 4'd0;
    model_q   = 4'b0000;

    // Reset from unknown q
    @(posedge clk); #1;
    check("rst_q", q, 4'b0000);
    check("rst_ready", {3'b0, cmd_ready}, 4'b0001);
    check("rst_busy", {3'b0, busy}, 4'b0000);
    check("rst_done", {3'b0, done}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // LOAD / SET / CLEAR
    do_cmd("load", 3'd1, 4'b1010, 4'd0, 1'b0);
    check("load_val", q, 4'b1010);
    do_cmd("set", 3'd3, 4'b0000, 4'd5, 1'b0);
    check("set_val", q, 4'b1111);
    do_cmd("clear", 3'd2, 4'b1111, 4'd5, 1'b0);
    check("clear_val", q, 4'b0000);

    // TOGGLE, reserved op, HOLD
    do_cmd("load2", 3'd1, 4'b1010, 4'd0, 1'b0);
    do_cmd("toggle", 3'd4, 4'b0110, 4'd0, 1'b0);
    check("toggle_val", q, 4'b1100);
    do_cmd("rsvd", 3'd7, 4'b1111, 4'd9, 1'b0);
    check("rsvd_val", q, 4'b1100);
    do_cmd("hold", 3'd0, 4'b0011, 4'd0, 1'b0);
    check("hold_val", q, 4'b1100);

    // COUNT across the wrap
    do_cmd("load3", 3'd1, 4'b1110, 4'd0, 1'b0);
    do_cmd("count", 3'd5, 4'b0000, 4'd2, 1'b0);
    check("count_val", q, 4'b0001);

    // SHIFT in ones
    do_cmd("clear2", 3'd2, 4'b0000, 4'd0, 1'b0);
    do_cmd("shift", 3'd6, 4'b0001, 4'd3, 1'b0);
    check("shift_val", q, 4'b1111);
    do_cmd("shift0", 3'd6, 4'b1110, 4'd1, 1'b0);
    check("shift0_val", q, 4'b1100);

    // Command presented while busy is ignored
    do_cmd("clear3", 3'd2, 4'b0000, 4'd0, 1'b0);
    do_cmd("count_noise", 3'd5, 4'b0000, 4'd3, 1'b1);
    check("count_noise_val", q, 4'b0100);

    // Reset in the middle of a long COUNT
    do_cmd("clear4", 3'd2, 4'b0000, 4'd0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    cmd_data  = 4'b0000;
    cmd_len   = 4'd15;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int unsigned s = 1; s <= 3; s++) begin
      @(posedge clk); #1;
      check("midrst_step", q, 4'(s));
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_q", q, 4'b0000);
    check("midrst_ready", {3'b0, cmd_ready}, 4'b0001);
    check("midrst_busy", {3'b0, busy}, 4'b0000);
    check("midrst_done", {3'b0, done}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      check("midrst_no_done", {3'b0, done}, 4'b0000);
      check("midrst_q_hold", q, 4'b0000);
    end

    // Reset coinciding with an accepting handshake drops the command
    @(negedge clk);
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 3'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("rst_hs_q", q, 4'b0000);
    check("rst_hs_busy", {3'b0, busy}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_hs_q2", q, 4'b0000);
    check("rst_hs_busy2", {3'b0, busy}, 4'b0000);
    model_q = 4'b0000;

    // Normal operation resumes after reset
    do_cmd("post_load", 3'd1, 4'b0101, 4'd0, 1'b0);
    check("post_load_val", q, 4'b0101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_reg_ctrl.md
# jk_reg_ctrl

Command-driven controller for a WIDTH-bit bank of JK flip-flop cells. It accepts one operation at a time over a valid/ready handshake: load, clear, set, toggle, count or shift. For every cell it drives J/K each cycle so the bank carries out that operation. Reset is done through the JK inputs themselves (J=0, K=1), so the storage cells need no reset pin. The block is the sequencer that sits between command sources and the plain JK register datapath.

## Interface
- WIDTH, 4: number of JK cells in the bank (≥2).
- clk  input  1  rising-edge clock for controller and all JK cells.
- rst_n  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  0 HOLD, 1 LOAD, 2 CLEAR, 3 SET, 4 TOGGLE, 5 COUNT, 6 SHIFT, 7 reserved.
- cmd_data  input  WIDTH  meaning depends on op:
  - LOAD: value to load.
  - TOGGLE: toggle mask.
  - SHIFT: bit 0 is the serial-in bit.
- cmd_len  input  4  COUNT/SHIFT repeat count minus 1 (0..15 gives 1..16 steps).
- q  output  WIDTH  JK bank outputs.
- busy  output  1  high when state != IDLE.
- done  output  1  one-cycle pulse when a command completes.

## Operation
- Internal blocks: WIDTH JK cells (hold/reset/set/toggle semantics, posedge clk), FSM, latched op/data, 4-bit step counter.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: cmd_ready=1. All J=K=0, so q holds. Acceptance happens when cmd_valid & cmd_ready at a rising edge; op, data and len are latched. Go to EXEC.
  - EXEC: J/K for each bit i are driven combinationally from the latched op:
    - LOAD: J=data[i], K=~data[i].
    - CLEAR: J=0, K=1.
    - SET: J=1, K=0.
    - TOGGLE: J=K=mask[i].
    - COUNT: J=K=AND(q[i-1:0]); bit 0 gets J=K=1.
    - SHIFT: next=(i==0 ? data[0] : q[i-1]); J=next, K=~next.
    - HOLD and op 7: J=K=0.
  - EXEC duration: COUNT and SHIFT stay for len+1 cycles. The counter decrements each cycle and EXEC leaves when it reaches 0. All other ops stay 1 cycle. Then go to DONE.
  - DONE: done=1, cmd_ready=0. Go to IDLE unconditionally.
- COUNT wraps modulo 2^WIDTH (all-ones becomes 0). SHIFT discards q[WIDTH-1].
- Op 7 is treated exactly as HOLD: q unchanged, done still pulses.
- cmd_valid while cmd_ready=0 is ignored. Inputs need not be held; only the values at the accepting edge matter.

## Timing
- Reset: an edge with rst_n=0 drives all cells J=0, K=1, overriding the FSM. After that edge:
  - q=0, state=IDLE, counter=0.
  - cmd_ready=1, busy=0, done=0.
- q is undefined before the first reset edge.
- Reset dominates every state, including mid-EXEC and DONE. An interrupted command produces no done pulse.
- Command accepted at edge t0:
  - First q update at edge t0+1.
  - Last q update at edge t0+L, where L=1, or len+1 for COUNT/SHIFT.
  - done=1 during the cycle after edge t0+L.
  - cmd_ready=1 again after edge t0+L+1.
- Throughput: one command per L+2 cycles.
- busy is registered from state: high from after t0 through the DONE cycle.
- done and cmd_ready are never high in the same cycle.
- Simultaneous rst_n=0 and an accepting handshake: reset wins and the command is dropped.

## Test plan (WIDTH=4)
- **Reset:** q=x, rst_n=0 for one edge → q=0000, cmd_ready=1, busy=0, done=0.
- **LOAD, SET, CLEAR:**
  - LOAD 1010 → q=1010 at t0+1, done high in the next cycle, cmd_ready back one cycle after that.
  - SET → 1111.
  - CLEAR → 0000.
- **TOGGLE and reserved op:**
  - q=1010, TOGGLE 0110 → 1100.
  - Op 7 → q stays 1100, done pulses once.
- **COUNT with wrap:** q=1110, COUNT len=2 → 1111, 0000, 0001 on three successive edges; done after the third.
- **SHIFT:** q=0000, SHIFT len=3, data[0]=1 → 0001, 0011, 0111, 1111.
- **Reset mid-command and ignored command:**
  - COUNT len=15 from 0000; assert rst_n=0 after 3 steps (q=0011) → q=0000 at that edge, IDLE, no done.
  - In a separate run, cmd_valid with new data held while busy → not accepted, q sequence unaffected.
